mem_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between two requesters: the instruction-fetch port (IF, read-only) and the data load/store port (D).
- Sits between pc/instr fetch and data_memory, replacing their independent direct accesses in the multi-cycle core.
- Sequences each access with a req/ack handshake and raises a stall so the pc holds while any access is outstanding.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the fetch port, the data port, the unified memory port and mem_arbiter.
// mem_arbiter connects through modport slave; the requesters and the memory model use modport master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_width;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_width;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_width, mem_ack, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               mem_width, stall, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_width, mem_ack, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
               mem_width, stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch vs. data) in front of one variable-latency memory port.
// Optional macro ARB_TIMEOUT_EN adds an abort after TIMEOUT grant cycles without mem_ack.
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        starve_cnt_reg;
    logic              grant_d_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [2:0]        mem_width_reg;
    logic [31:0]       if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              in_grant;
    logic              starve_max;
    logic              timeout_hit;
    logic              err_reg;
    logic              done_pulse;

    assign in_grant   = (state_reg == GNT_IF) || (state_reg == GNT_D);
    assign starve_max = (starve_cnt_reg == 4'(MAX_WAIT));

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    logic [TMO_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            tmo_cnt_reg <= in_grant ? tmo_cnt_reg + 1'b1 : '0;
            err_reg     <= timeout_hit;
        end
    end

    // An ack arriving in the expiry cycle takes precedence over the abort.
    assign timeout_hit = in_grant && !bus.mem_ack && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    assign err_reg     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && starve_max)) state_next = GNT_D;
                else if (bus.if_req)                          state_next = GNT_IF;
            end
            GNT_IF, GNT_D: begin
                if (bus.mem_ack || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_reg <= '0;
            grant_d_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_width_reg  <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
        end else begin
            if (state_reg == IDLE) begin
                if (state_next == GNT_D) begin
                    grant_d_reg   <= 1'b1;
                    mem_we_reg    <= bus.d_we;
                    mem_addr_reg  <= bus.d_addr;
                    mem_wdata_reg <= bus.d_wdata;
                    mem_width_reg <= bus.d_width;
                end else if (state_next == GNT_IF) begin
                    grant_d_reg   <= 1'b0;
                    mem_we_reg    <= 1'b0;
                    mem_addr_reg  <= bus.if_addr;
                    mem_wdata_reg <= '0;
                    mem_width_reg <= 3'b010;
                end
                // D only wins a contested arbitration while the counter is below MAX_WAIT.
                if (state_next == GNT_IF || !bus.if_req)
                    starve_cnt_reg <= '0;
                else if (state_next == GNT_D && !starve_max)
                    starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
            if (in_grant && bus.mem_ack) begin
                if (!grant_d_reg)     if_rdata_reg <= bus.mem_rdata[31:0];
                else if (!mem_we_reg) d_rdata_reg  <= bus.mem_rdata;
            end else if (timeout_hit) begin
                if (!grant_d_reg) if_rdata_reg <= '0;
                else              d_rdata_reg  <= '0;
            end
        end
    end

    always_comb begin
        done_pulse    = (state_reg == DONE);
        bus.mem_req   = in_grant;
        bus.mem_we    = mem_we_reg;
        bus.mem_addr  = mem_addr_reg;
        bus.mem_wdata = mem_wdata_reg;
        bus.mem_width = mem_width_reg;
        bus.if_done   = done_pulse && !grant_d_reg;
        bus.d_done    = done_pulse && grant_d_reg;
        bus.if_rdata  = if_rdata_reg;
        bus.d_rdata   = d_rdata_reg;
        bus.stall     = (bus.if_req | bus.d_req) & ~done_pulse;
        bus.err       = err_reg;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch-only, contention, starvation, reset abort, back-to-back loads
// and the timeout path (or the indefinite wait when ARB_TIMEOUT_EN is not defined).
module tb_mem_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0b exp=0", bus.mem_req); else passed++;
        checks++; if (bus.if_done !== 1'b0 || bus.d_done !== 1'b0) $display("FAIL rst_done got=%0b%0b exp=00", bus.if_done, bus.d_done); else passed++;
        checks++; if (bus.stall !== 1'b0 || bus.err !== 1'b0) $display("FAIL rst_stall_err got=%0b%0b exp=00", bus.stall, bus.err); else passed++;
        checks++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 64'h0) $display("FAIL rst_rdata got=%h/%h exp=0", bus.if_rdata, bus.d_rdata); else passed++;
        checks++; if (bus.mem_addr !== 12'h0) $display("FAIL rst_mem_addr got=%h exp=000", bus.mem_addr); else passed++;
        rst = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_if_only();
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h040;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL if_grant req/we got=%0b%0b exp=10", bus.mem_req, bus.mem_we); else passed++;
        checks++; if (bus.mem_width !== 3'b010 || bus.mem_addr !== 12'h040) $display("FAIL if_payload got=%b/%h exp=010/040", bus.mem_width, bus.mem_addr); else passed++;
        checks++; if (bus.mem_wdata !== 64'h0 || bus.stall !== 1'b1) $display("FAIL if_wdata_stall got=%h/%0b exp=0/1", bus.mem_wdata, bus.stall); else passed++;
        tick();
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.if_done !== 1'b0) $display("FAIL if_hold got=%0b%0b exp=10", bus.mem_req, bus.if_done); else passed++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hFFFF_0000_0000_0013;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h13) $display("FAIL if_done got=%0b/%h exp=1/00000013", bus.if_done, bus.if_rdata); else passed++;
        checks++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL if_done_stall got=%0b%0b exp=00", bus.stall, bus.mem_req); else passed++;
        bus.if_req = 1'b0;
        tick();
        checks++; if (bus.if_done !== 1'b0 || bus.if_rdata !== 32'h13) $display("FAIL if_after got=%0b/%h exp=0/00000013", bus.if_done, bus.if_rdata); else passed++;
        $display("txn IF addr=040 rdata=%h", bus.if_rdata);
    endtask

    task automatic test_simultaneous();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 12'h100;
        bus.d_wdata = 64'hDEAD_BEEF;
        bus.d_width = 3'b011;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h080;
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h100) $display("FAIL sim_d_grant got=%0b/%h exp=1/100", bus.mem_we, bus.mem_addr); else passed++;
        checks++; if (bus.mem_wdata !== 64'hDEAD_BEEF || bus.mem_width !== 3'b011) $display("FAIL sim_d_payload got=%h/%b exp=deadbeef/011", bus.mem_wdata, bus.mem_width); else passed++;
        checks++; if (dut.starve_cnt_reg !== 4'd1) $display("FAIL sim_starve1 got=%0d exp=1", dut.starve_cnt_reg); else passed++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h5555;
        tick();
        bus.mem_ack = 1'b0;
        bus.d_req   = 1'b0;
        checks++; if (bus.d_done !== 1'b1 || bus.if_done !== 1'b0) $display("FAIL sim_d_done got=%0b%0b exp=10", bus.d_done, bus.if_done); else passed++;
        checks++; if (bus.d_rdata !== 64'h0) $display("FAIL sim_store_rdata got=%h exp=0", bus.d_rdata); else passed++;
        tick();
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL sim_gap got=%0b exp=0", bus.mem_req); else passed++;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h080 || bus.mem_we !== 1'b0) $display("FAIL sim_if_grant got=%0b/%h/%0b exp=1/080/0", bus.mem_req, bus.mem_addr, bus.mem_we); else passed++;
        checks++; if (dut.starve_cnt_reg !== 4'd0) $display("FAIL sim_starve0 got=%0d exp=0", dut.starve_cnt_reg); else passed++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h93;
        tick();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h93) $display("FAIL sim_if_done got=%0b/%h exp=1/00000093", bus.if_done, bus.if_rdata); else passed++;
        tick();
        $display("txn D store 100 then IF 080");
    endtask

    task automatic test_starvation();
        bit exp_d;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h0C0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        for (int r = 0; r < 5; r++) begin
            exp_d      = (r < 4);
            bus.d_addr = 12'h200 + 12'(r);
            tick();
            checks++; if (bus.mem_addr !== (exp_d ? 12'h200 + 12'(r) : 12'h0C0)) $display("FAIL starve_grant%0d got=%h exp_d=%0b", r, bus.mem_addr, exp_d); else passed++;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 64'h1000 + 64'(r);
            tick();
            bus.mem_ack = 1'b0;
            checks++; if (bus.d_done !== exp_d || bus.if_done !== !exp_d) $display("FAIL starve_done%0d got=%0b%0b exp_d=%0b", r, bus.d_done, bus.if_done, exp_d); else passed++;
            if (r == 4) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            tick();
            $display("txn starvation round %0d winner=%s", r, exp_d ? "D" : "IF");
        end
        checks++; if (bus.if_rdata !== 32'h1004 || bus.d_rdata !== 64'h1003) $display("FAIL starve_rdata got=%h/%h exp=1004/1003", bus.if_rdata, bus.d_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 12'h010;
        tick();
        checks++; if (bus.stall !== 1'b1 || bus.mem_addr !== 12'h010) $display("FAIL b2b_grant1 got=%0b/%h exp=1/010", bus.stall, bus.mem_addr); else passed++;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1122_3344_5566_7788;
        tick();
        bus.mem_ack = 1'b0;
        bus.d_addr  = 12'h018;
        checks++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 64'h1122_3344_5566_7788) $display("FAIL b2b_done1 got=%0b/%h exp=1/1122334455667788", bus.d_done, bus.d_rdata); else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.stall !== 1'b1 || bus.d_done !== 1'b0) $display("FAIL b2b_between%0d got=%0b%0b exp=10", k, bus.stall, bus.d_done); else passed++;
            if (k == 2) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 64'h0;
            end
        end
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 64'h0 || bus.mem_addr !== 12'h018) $display("FAIL b2b_done2 got=%0b/%h/%h exp=1/0/018", bus.d_done, bus.d_rdata, bus.mem_addr); else passed++;
        bus.d_req = 1'b0;
        tick();
        checks++; if (bus.stall !== 1'b0 || bus.d_done !== 1'b0) $display("FAIL b2b_idle got=%0b%0b exp=00", bus.stall, bus.d_done); else passed++;
        $display("txn back-to-back loads 010,018");
    endtask

    task automatic test_reset_mid();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 12'h300;
        tick();
        checks++; if (bus.mem_req !== 1'b1) $display("FAIL rmid_grant got=%0b exp=1", bus.mem_req); else passed++;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || bus.d_done !== 1'b0) $display("FAIL rmid_abort got=%0b%0b exp=00", bus.mem_req, bus.d_done); else passed++;
        rst           = 1'b1;
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h77;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.d_done !== 1'b0 || bus.d_rdata !== 64'h0 || bus.mem_req !== 1'b0) $display("FAIL rmid_late_ack got=%0b/%h/%0b exp=0/0/0", bus.d_done, bus.d_rdata, bus.mem_req); else passed++;
        tick();
        checks++; if (bus.d_done !== 1'b0) $display("FAIL rmid_no_done got=%0b exp=0", bus.d_done); else passed++;
        $display("txn reset mid-access addr=300");
    endtask

    task automatic test_timeout();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 12'h3E0;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hCAFE;
        tick();
        bus.mem_ack = 1'b0;
        bus.d_addr  = 12'h3F0;
        checks++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 64'hCAFE) $display("FAIL tmo_pre_load got=%0b/%h exp=1/cafe", bus.d_done, bus.d_rdata); else passed++;
        tick();
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.err !== 1'b0) $display("FAIL tmo_last_grant got=%0b%0b exp=10", bus.mem_req, bus.err); else passed++;
        tick();
        checks++; if (bus.err !== 1'b1 || bus.d_done !== 1'b1) $display("FAIL tmo_err got=%0b%0b exp=11", bus.err, bus.d_done); else passed++;
        checks++; if (bus.d_rdata !== 64'h0 || bus.mem_req !== 1'b0) $display("FAIL tmo_rdata got=%h/%0b exp=0/0", bus.d_rdata, bus.mem_req); else passed++;
        bus.d_req = 1'b0;
        tick();
        checks++; if (bus.err !== 1'b0 || bus.d_done !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL tmo_idle got=%0b%0b%0b exp=000", bus.err, bus.d_done, bus.mem_req); else passed++;
        $display("txn timeout load addr=3F0");
`else
        for (int k = 0; k < 20; k++) tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.err !== 1'b0) $display("FAIL wait_hold got=%0b%0b exp=10", bus.mem_req, bus.err); else passed++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hBEEF;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 64'hBEEF || bus.err !== 1'b0) $display("FAIL wait_done got=%0b/%h/%0b exp=1/beef/0", bus.d_done, bus.d_rdata, bus.err); else passed++;
        bus.d_req = 1'b0;
        tick();
        $display("txn long-wait load addr=3F0");
`endif
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst           = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_width   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_if_only();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
